// File: rtl/route_header_encoder_if.sv
// Handshake bundle between the core, the injection encoder and the local router.
// The encoder takes the slave side; the core/router model takes the master side.
interface route_header_encoder_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BODY = 2
);
  localparam int unsigned DIR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                       core_valid;
  logic                       core_ready;
  logic [WIDTH-1:0]           core_dst;
  logic [NUM_BODY*DATA_W-1:0] core_payload;

  logic                       rtr_valid;
  logic                       rtr_ready;
  logic [DATA_W-1:0]          rtr_flit;
  logic                       rtr_head;
  logic                       rtr_tail;
  logic [DIR_W-1:0]           rtr_dir;

  logic                       loop_valid;
  logic                       loop_ready;
  logic [NUM_BODY*DATA_W-1:0] loop_data;

  modport master (
    output core_valid, core_dst, core_payload, rtr_ready, loop_ready,
    input  core_ready, rtr_valid, rtr_flit, rtr_head, rtr_tail, rtr_dir,
           loop_valid, loop_data
  );

  modport slave (
    input  core_valid, core_dst, core_payload, rtr_ready, loop_ready,
    output core_ready, rtr_valid, rtr_flit, rtr_head, rtr_tail, rtr_dir,
           loop_valid, loop_data
  );
endinterface

// File: rtl/route_header_encoder.sv
// Injection-side packetizer: header flit (relative address) plus NUM_BODY body flits
// toward the router, or whole-packet loopback to the core when the destination is local.
module route_header_encoder #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] ADDR     = '0,
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      NUM_BODY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  route_header_encoder_if.slave bus,
  output logic [15:0]           pkt_count
);
  localparam int unsigned DIR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = (NUM_BODY > 1) ? $clog2(NUM_BODY) : 1;
  localparam int unsigned PAY_W = NUM_BODY * DATA_W;

  typedef enum logic [1:0] {IDLE, LOOP, HEAD, BODY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rel_q, rel_d;
  logic [PAY_W-1:0]   pay_q, pay_d;
  logic               pkt_done;
  logic               last_body;
  logic [DIR_W-1:0]   low_dir;
  logic [DATA_W-1:0]  body_flit;

  assign last_body = (cnt_q == CNT_W'(NUM_BODY - 1));

  // First-hop direction: index of the lowest set bit of the latched relative address.
  always_comb begin
    logic found;
    found   = 1'b0;
    low_dir = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (rel_q[i] && !found) begin
        low_dir = DIR_W'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    body_flit = '0;
    for (int unsigned i = 0; i < NUM_BODY; i++) begin
      if (cnt_q == CNT_W'(i)) body_flit = pay_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rel_d          = rel_q;
    pay_d          = pay_q;
    pkt_done       = 1'b0;
    bus.core_ready = 1'b0;
    bus.rtr_valid  = 1'b0;
    bus.rtr_head   = 1'b0;
    bus.rtr_tail   = 1'b0;
    bus.rtr_flit   = '0;
    bus.rtr_dir    = '0;
    bus.loop_valid = 1'b0;
    bus.loop_data  = '0;
    case (state_q)
      IDLE: begin
        bus.core_ready = 1'b1;
        if (bus.core_valid) begin
          rel_d   = bus.core_dst ^ ADDR;
          pay_d   = bus.core_payload;
          state_d = (rel_d == '0) ? LOOP : HEAD;
        end
      end
      LOOP: begin
        bus.loop_valid = 1'b1;
        bus.loop_data  = pay_q;
        if (bus.loop_ready) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      HEAD: begin
        bus.rtr_valid = 1'b1;
        bus.rtr_head  = 1'b1;
        bus.rtr_flit  = DATA_W'(rel_q);
        bus.rtr_dir   = low_dir;
        if (bus.rtr_ready) begin
          cnt_d   = '0;
          state_d = BODY;
        end
      end
      BODY: begin
        bus.rtr_valid = 1'b1;
        bus.rtr_flit  = body_flit;
        bus.rtr_tail  = last_body;
        bus.rtr_dir   = low_dir;
        if (bus.rtr_ready) begin
          if (last_body) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rel_q     <= '0;
      pay_q     <= '0;
      pkt_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      pay_q   <= pay_d;
      if (pkt_done) pkt_count <= pkt_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_route_header_encoder.sv
// Directed bench for route_header_encoder at WIDTH=4, ADDR=4'b0101, DATA_W=8, NUM_BODY=2.
module tb_route_header_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt_count;
  int          total = 0;
  int          bad = 0;

  route_header_encoder_if #(.WIDTH(4), .DATA_W(8), .NUM_BODY(2)) bus ();

  route_header_encoder #(
    .WIDTH(4), .ADDR(4'b0101), .DATA_W(8), .NUM_BODY(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Router and loopback valids must never overlap.
  always @(negedge clk)
    if (rst_n) chk("excl", 32'(bus.rtr_valid & bus.loop_valid), 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one packet for one cycle; afterwards the header/loop cycle is current.
  task automatic send(input logic [3:0] dst, input logic [15:0] pay);
    bus.core_valid   = 1'b1;
    bus.core_dst     = dst;
    bus.core_payload = pay;
    chk("accept_ready", 32'(bus.core_ready), 32'd1);
    step();
    bus.core_valid = 1'b0;
  endtask

  task automatic flit(input string tag, input logic [7:0] f, input logic h,
                      input logic t, input logic [1:0] d, input logic check_dir);
    chk({tag, "_valid"}, 32'(bus.rtr_valid), 32'd1);
    chk({tag, "_flit"}, 32'(bus.rtr_flit), 32'(f));
    chk({tag, "_head"}, 32'(bus.rtr_head), 32'(h));
    chk({tag, "_tail"}, 32'(bus.rtr_tail), 32'(t));
    chk({tag, "_cready"}, 32'(bus.core_ready), 32'd0);
    if (check_dir) chk({tag, "_dir"}, 32'(bus.rtr_dir), 32'(d));
  endtask

  task automatic idle_chk(input string tag, input logic [15:0] cnt);
    chk({tag, "_rvalid"}, 32'(bus.rtr_valid), 32'd0);
    chk({tag, "_lvalid"}, 32'(bus.loop_valid), 32'd0);
    chk({tag, "_cready"}, 32'(bus.core_ready), 32'd1);
    chk({tag, "_count"}, 32'(pkt_count), 32'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.core_valid   = 1'b0;
    bus.core_dst     = '0;
    bus.core_payload = '0;
    bus.rtr_ready    = 1'b1;
    bus.loop_ready   = 1'b1;
    repeat (2) step();
    chk("rst_flit", 32'(bus.rtr_flit), 32'd0);
    chk("rst_data", 32'(bus.loop_data), 32'd0);
    rst_n = 1'b1;
    step();
    idle_chk("reset", 16'd0);

    // Router packet: rel = 0111 ^ 0101 = 0010
    send(4'b0111, 16'hBEEF);
    flit("p1h", 8'h02, 1'b1, 1'b0, 2'd1, 1'b1);
    step();
    flit("p1b0", 8'hEF, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    flit("p1b1", 8'hBE, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    idle_chk("p1done", 16'd1);

    // Local destination loops back.
    send(4'b0101, 16'hBEEF);
    chk("lp_valid", 32'(bus.loop_valid), 32'd1);
    chk("lp_data", 32'(bus.loop_data), 32'h0000BEEF);
    chk("lp_rvalid", 32'(bus.rtr_valid), 32'd0);
    step();
    idle_chk("lpdone", 16'd2);

    // Router stalls the header for 3 cycles; core inputs must be ignored meanwhile.
    bus.rtr_ready = 1'b0;
    send(4'b0111, 16'h1234);
    bus.core_valid = 1'b1;
    bus.core_dst   = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      flit("stall", 8'h02, 1'b1, 1'b0, 2'd1, 1'b1);
      if (i == 2) bus.rtr_ready = 1'b1;
      step();
    end
    bus.core_valid = 1'b0;
    flit("st_b0", 8'h34, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    flit("st_b1", 8'h12, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    idle_chk("stdone", 16'd3);

    // Direction boundaries: rel 1000 -> dir 3, rel 0001 -> dir 0.
    send(4'b1101, 16'hA55A);
    flit("d3h", 8'h08, 1'b1, 1'b0, 2'd3, 1'b1);
    step();
    flit("d3b0", 8'h5A, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    flit("d3b1", 8'hA5, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    send(4'b0100, 16'h0FF0);
    flit("d0h", 8'h01, 1'b1, 1'b0, 2'd0, 1'b1);
    step();
    flit("d0b0", 8'hF0, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    flit("d0b1", 8'h0F, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    idle_chk("ddone", 16'd5);

    // Reset during first body flit aborts the packet at once.
    send(4'b0111, 16'hBEEF);
    step();
    flit("ab_b0", 8'hEF, 1'b0, 1'b0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_rvalid", 32'(bus.rtr_valid), 32'd0);
    chk("ab_flit", 32'(bus.rtr_flit), 32'd0);
    chk("ab_tail", 32'(bus.rtr_tail), 32'd0);
    chk("ab_head", 32'(bus.rtr_head), 32'd0);
    chk("ab_lvalid", 32'(bus.loop_valid), 32'd0);
    chk("ab_count", 32'(pkt_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send(4'b0111, 16'hBEEF);
    flit("rs_h", 8'h02, 1'b1, 1'b0, 2'd1, 1'b1);
    step();
    flit("rs_b0", 8'hEF, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    flit("rs_b1", 8'hBE, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    idle_chk("rsdone", 16'd1);

    // Loopback stalled 2 cycles, then a router packet: three packets since reset.
    bus.loop_ready = 1'b0;
    send(4'b0101, 16'hCAFE);
    for (int i = 0; i < 2; i++) begin
      chk("lh_valid", 32'(bus.loop_valid), 32'd1);
      chk("lh_data", 32'(bus.loop_data), 32'h0000CAFE);
      chk("lh_cready", 32'(bus.core_ready), 32'd0);
      step();
    end
    bus.loop_ready = 1'b1;
    chk("lh_valid2", 32'(bus.loop_valid), 32'd1);
    step();
    chk("lh_count", 32'(pkt_count), 32'd2);
    send(4'b1101, 16'h7711);
    flit("m3h", 8'h08, 1'b1, 1'b0, 2'd3, 1'b1);
    step();
    step();
    flit("m3b1", 8'h77, 1'b0, 1'b1, 2'd0, 1'b0);
    step();
    idle_chk("mixdone", 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
